xsleena_rom_loader: RTL and testbench
=====================================

XSLEENA_ROM_LOADER -- requirements
Module: xsleena_rom_loader

Interface
REQ-001 SHALL have parameter WR_HOLD, default 2: cycles each BRAM write strobe is held (1..7).
REQ-002 SHALL have parameter REGIONS, default 8: number of ROM regions, each with a one-hot chip select.
REQ-003 SHALL have port clk, input, 1: sole clock; single clock domain; all logic samples on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port dl_en, input, 1: download session active.
REQ-006 SHALL have port dl_wr, input, 1: single-cycle byte-valid strobe.
REQ-007 SHALL have port dl_addr, input, 25: absolute byte address in the download image.
REQ-008 SHALL have port dl_data, input, 8: download byte.
REQ-009 SHALL have port dl_wait, output, 1: host must not issue dl_wr while high.
REQ-010 SHALL have port bram_wr, output, 1: write strobe to the region ROM port 0.
REQ-011 SHALL have port bram_addr, output, 20: byte offset within the selected region.
REQ-012 SHALL have port bram_data, output, 8: write data.
REQ-013 SHALL have port bram_cs, output, REGIONS: one-hot region select; all zero when idle.
REQ-014 SHALL have port done, output, 1: session finished with at least one byte written.
REQ-015 SHALL have port err_unmapped, output, 1: sticky; a byte fell outside every region.
REQ-016 SHALL have port err_overrun, output, 1: sticky; dl_wr arrived while dl_wait high.
REQ-017 SHALL have port checksum, output, 8: modulo-256 sum of all bytes written this session.

Function
REQ-018 SHALL implement FSM states IDLE, ARMED, WRITE, DONE.
REQ-019 IDLE -> ARMED on dl_en high; SHALL clear done, both error flags and checksum on that transition.
REQ-020 In ARMED, dl_wr SHALL register dl_addr and dl_data and decode the region in the same cycle.
REQ-021 Region i matches when base_i <= dl_addr < base_i + size_i; lowest index wins on any overlap.
REQ-022 On a match, the FSM SHALL enter WRITE next cycle with bram_wr=1, bram_cs one-hot, bram_addr = dl_addr - base_i (low 20 bits), bram_data registered; latency dl_wr -> bram_wr is exactly 1 cycle.
REQ-023 WRITE SHALL hold bram_wr, bram_cs, bram_addr and bram_data stable for exactly WR_HOLD cycles, then return to ARMED with bram_wr=0 and bram_cs=0.
REQ-024 dl_wait SHALL be high from the cycle after an accepted dl_wr through the last WRITE cycle; it is low in ARMED.
REQ-025 On no region match: no write, state stays ARMED, err_unmapped set, checksum unchanged.
REQ-026 dl_wr while dl_wait is high SHALL be ignored and SHALL set err_overrun.
REQ-027 checksum SHALL add bram_data once per completed write, wrapping mod 256.
REQ-028 dl_en falling in ARMED SHALL go to DONE if at least one byte was written this session, else IDLE; dl_en falling in WRITE SHALL finish the hold first, then go to DONE.
REQ-029 In DONE, done SHALL stay high and checksum SHALL stay frozen until dl_en rises (-> ARMED, as REQ-019) or reset.
REQ-030 dl_wr with dl_en low SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE and drive every output to 0 (dl_wait, bram_wr, bram_addr, bram_data, bram_cs, done, err_unmapped, err_overrun, checksum) on the next edge.
REQ-032 reset mid-WRITE SHALL abort the write with no further strobe cycles; the partial write is not counted in checksum.

Structure
REQ-033 Package xsleena_rom_pkg SHALL hold the region base/size table and the state enum; region 3 = MAP tile ROM, base 0x30000, size 0x8000.
REQ-034 Region decode SHALL be one sub-module, xsleena_rom_region_dec (addr in; hit, one-hot, offset out; purely combinational).

Verification
REQ-035 dl_en=1, dl_wr at 0x30005 with data 0xA5 -> next cycle bram_wr=1, bram_cs=0x08, bram_addr=0x00005, bram_data=0xA5, held 2 cycles; dl_wait high 2 cycles.
REQ-036 Write 0x10, 0x20, 0xF0 to mapped addresses, then drop dl_en -> done=1, checksum=0x20.
REQ-037 dl_wr at an unmapped address -> no bram_wr, err_unmapped=1, state stays ARMED.
REQ-038 dl_wr issued one cycle after an accepted dl_wr -> second byte dropped, err_overrun=1, first write completes unchanged.
REQ-039 reset asserted during the first WRITE cycle -> next cycle all outputs 0, state IDLE, checksum 0x00.
REQ-040 dl_en pulsed high then low with no writes -> returns to IDLE, done stays 0.

Source files
------------

// File: rtl/xsleena_rom_pkg.sv
// Shared definitions for the Xain'd Sleena ROM download loader:
// loader state encoding and the ROM region map (base/size per region).
package xsleena_rom_pkg;

  localparam int unsigned ADDR_W      = 25;
  localparam int unsigned OFFS_W      = 20;
  localparam int unsigned MAX_REGIONS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_e;

  // Region base address in the download image. Indices past the table
  // return a zero-sized region and therefore never match.
  function automatic logic [ADDR_W-1:0] region_base(input int unsigned idx);
    case (idx)
      0:       return 25'h000000;  // main CPU program
      1:       return 25'h010000;  // sub CPU program
      2:       return 25'h020000;  // sound CPU program
      3:       return 25'h030000;  // MAP tile ROM
      4:       return 25'h038000;  // character ROM
      5:       return 25'h040000;  // sprite ROM
      6:       return 25'h060000;  // background tile ROM
      7:       return 25'h080000;  // MCU / PROMs
      default: return '0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] region_size(input int unsigned idx);
    case (idx)
      0:       return 25'h010000;
      1:       return 25'h010000;
      2:       return 25'h010000;
      3:       return 25'h008000;
      4:       return 25'h008000;
      5:       return 25'h020000;
      6:       return 25'h020000;
      7:       return 25'h010000;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/xsleena_rom_region_dec.sv
// Combinational region decoder: maps an absolute download address to a
// one-hot region select and the byte offset inside that region.
module xsleena_rom_region_dec
  import xsleena_rom_pkg::*;
#(
  parameter int unsigned REGIONS = 8
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               hit_o,
  output logic [REGIONS-1:0] onehot_o,
  output logic [OFFS_W-1:0]  offset_o
);

  // First matching region in ascending index order wins on overlap.
  always_comb begin
    hit_o    = 1'b0;
    onehot_o = '0;
    offset_o = '0;
    for (int unsigned i = 0; i < REGIONS; i++) begin
      if (!hit_o && (addr_i >= region_base(i)) &&
          ({1'b0, addr_i} < ({1'b0, region_base(i)} + {1'b0, region_size(i)}))) begin
        hit_o       = 1'b1;
        onehot_o[i] = 1'b1;
        offset_o    = OFFS_W'(addr_i - region_base(i));
      end
    end
  end

endmodule

// File: rtl/xsleena_rom_loader.sv
// Download-to-BRAM loader: accepts bytes from the host download port,
// routes each to its ROM region and holds the write strobe WR_HOLD cycles.
module xsleena_rom_loader
  import xsleena_rom_pkg::*;
#(
  parameter int unsigned WR_HOLD = 2,
  parameter int unsigned REGIONS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dl_en,
  input  logic               dl_wr,
  input  logic [24:0]        dl_addr,
  input  logic [7:0]         dl_data,
  output logic               dl_wait,
  output logic               bram_wr,
  output logic [19:0]        bram_addr,
  output logic [7:0]         bram_data,
  output logic [REGIONS-1:0] bram_cs,
  output logic               done,
  output logic               err_unmapped,
  output logic               err_overrun,
  output logic [7:0]         checksum
);

  ld_state_e          state_q, state_d;
  logic [2:0]         hold_q, hold_d;
  logic [19:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [REGIONS-1:0] cs_q, cs_d;
  logic [7:0]         csum_q, csum_d;
  logic               wrote_q, wrote_d;
  logic               eunm_q, eunm_d;
  logic               eovr_q, eovr_d;

  logic               dec_hit;
  logic [REGIONS-1:0] dec_onehot;
  logic [19:0]        dec_offset;

  xsleena_rom_region_dec #(
    .REGIONS (REGIONS)
  ) u_dec (
    .addr_i   (dl_addr),
    .hit_o    (dec_hit),
    .onehot_o (dec_onehot),
    .offset_o (dec_offset)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cs_q    <= '0;
      csum_q  <= '0;
      wrote_q <= 1'b0;
      eunm_q  <= 1'b0;
      eovr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      csum_q  <= csum_d;
      wrote_q <= wrote_d;
      eunm_q  <= eunm_d;
      eovr_q  <= eovr_d;
    end
  end

  // Next-state logic: session start clears status, ARMED accepts bytes,
  // WRITE counts down the strobe hold and folds the byte into the checksum.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cs_d    = cs_q;
    csum_d  = csum_q;
    wrote_d = wrote_q;
    eunm_d  = eunm_q;
    eovr_d  = eovr_q;
    case (state_q)
      IDLE, DONE: begin
        if (dl_en) begin
          state_d = ARMED;
          csum_d  = '0;
          wrote_d = 1'b0;
          eunm_d  = 1'b0;
          eovr_d  = 1'b0;
        end
      end
      ARMED: begin
        if (!dl_en) begin
          state_d = wrote_q ? DONE : IDLE;
        end else if (dl_wr) begin
          if (dec_hit) begin
            state_d = WRITE;
            addr_d  = dec_offset;
            data_d  = dl_data;
            cs_d    = dec_onehot;
            hold_d  = 3'(WR_HOLD - 1);
          end else begin
            eunm_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (dl_wr) eovr_d = 1'b1;
        if (hold_q == '0) begin
          csum_d  = csum_q + data_q;
          wrote_d = 1'b1;
          cs_d    = '0;
          state_d = dl_en ? ARMED : DONE;
        end else begin
          hold_d = hold_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are gated by WRITE so they read zero whenever no strobe is live.
  always_comb begin
    bram_wr      = (state_q == WRITE);
    dl_wait      = bram_wr;
    bram_addr    = bram_wr ? addr_q : '0;
    bram_data    = bram_wr ? data_q : '0;
    bram_cs      = cs_q;
    done         = (state_q == DONE);
    err_unmapped = eunm_q;
    err_overrun  = eovr_q;
    checksum     = csum_q;
  end

endmodule

// File: tb/tb_xsleena_rom_loader.sv
// Directed self-checking bench for xsleena_rom_loader (WR_HOLD=2, 8 regions).
module tb_xsleena_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_en;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        bram_wr;
  logic [19:0] bram_addr;
  logic [7:0]  bram_data;
  logic [7:0]  bram_cs;
  logic        done;
  logic        err_unmapped;
  logic        err_overrun;
  logic [7:0]  checksum;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  xsleena_rom_loader #(
    .WR_HOLD (2),
    .REGIONS (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dl_en        (dl_en),
    .dl_wr        (dl_wr),
    .dl_addr      (dl_addr),
    .dl_data      (dl_data),
    .dl_wait      (dl_wait),
    .bram_wr      (bram_wr),
    .bram_addr    (bram_addr),
    .bram_data    (bram_data),
    .bram_cs      (bram_cs),
    .done         (done),
    .err_unmapped (err_unmapped),
    .err_overrun  (err_overrun),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".dl_wait"},   32'(dl_wait), 0);
    check({tag, ".bram_wr"},   32'(bram_wr), 0);
    check({tag, ".bram_addr"}, 32'(bram_addr), 0);
    check({tag, ".bram_data"}, 32'(bram_data), 0);
    check({tag, ".bram_cs"},   32'(bram_cs), 0);
    check({tag, ".done"},      32'(done), 0);
    check({tag, ".err_unm"},   32'(err_unmapped), 0);
    check({tag, ".err_ovr"},   32'(err_overrun), 0);
    check({tag, ".checksum"},  32'(checksum), 0);
  endtask

  // Issue one byte, then check both strobe cycles and the return to ARMED.
  task automatic write_byte(input string tag, input logic [24:0] a, input logic [7:0] d,
                            input logic [7:0] exp_cs, input logic [19:0] exp_off);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 1'b0;
    for (int unsigned c = 0; c < 2; c++) begin
      check({tag, ".wr"},   32'(bram_wr), 1);
      check({tag, ".cs"},   32'(bram_cs), 32'(exp_cs));
      check({tag, ".addr"}, 32'(bram_addr), 32'(exp_off));
      check({tag, ".data"}, 32'(bram_data), 32'(d));
      check({tag, ".wait"}, 32'(dl_wait), 1);
      tick();
    end
    check({tag, ".wr_end"},   32'(bram_wr), 0);
    check({tag, ".cs_end"},   32'(bram_cs), 0);
    check({tag, ".wait_end"}, 32'(dl_wait), 0);
  endtask

  initial begin
    reset = 1'b1; dl_en = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Single MAP-ROM write.
    dl_en = 1'b1;
    tick();
    check("armed.wait", 32'(dl_wait), 0);
    write_byte("map", 25'h030005, 8'hA5, 8'h08, 20'h00005);
    check("map.csum", 32'(checksum), 32'hA5);
    dl_en = 1'b0;
    tick();
    check("map.done", 32'(done), 1);
    check("map.csum_done", 32'(checksum), 32'hA5);
    tick();
    check("done.frozen", 32'(checksum), 32'hA5);

    // New session: three bytes across region boundaries, checksum wraps.
    dl_en = 1'b1;
    tick();
    check("sess2.done_clr", 32'(done), 0);
    check("sess2.csum_clr", 32'(checksum), 0);
    write_byte("b10", 25'h037FFF, 8'h10, 8'h08, 20'h07FFF);
    write_byte("b20", 25'h038000, 8'h20, 8'h10, 20'h00000);
    write_byte("bF0", 25'h08FFFF, 8'hF0, 8'h80, 20'h0FFFF);
    dl_en = 1'b0;
    tick();
    check("sum.done", 32'(done), 1);
    check("sum.csum", 32'(checksum), 32'h20);

    // Unmapped byte, then overrun during a write.
    dl_en = 1'b1;
    tick();
    dl_wr = 1'b1; dl_addr = 25'h090000; dl_data = 8'h77;
    tick();
    dl_wr = 1'b0;
    check("unm.wr", 32'(bram_wr), 0);
    check("unm.flag", 32'(err_unmapped), 1);
    check("unm.wait", 32'(dl_wait), 0);
    check("unm.csum", 32'(checksum), 0);
    dl_wr = 1'b1; dl_addr = 25'h000010; dl_data = 8'h11;
    tick();
    dl_addr = 25'h000020; dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    check("ovr.flag", 32'(err_overrun), 1);
    check("ovr.wr", 32'(bram_wr), 1);
    check("ovr.addr", 32'(bram_addr), 32'h10);
    check("ovr.data", 32'(bram_data), 32'h11);
    check("ovr.cs", 32'(bram_cs), 32'h01);
    tick();
    check("ovr.end", 32'(bram_wr), 0);
    check("ovr.csum", 32'(checksum), 32'h11);
    check("ovr.unm_sticky", 32'(err_unmapped), 1);

    // Reset in the first WRITE cycle aborts the write.
    dl_wr = 1'b1; dl_addr = 25'h030000; dl_data = 8'h55;
    tick();
    dl_wr = 1'b0;
    check("rst.pre_wr", 32'(bram_wr), 1);
    reset = 1'b1;
    tick();
    check_all_zero("rstw");
    reset = 1'b0; dl_en = 1'b0;
    tick();
    check_all_zero("rstw.after");

    // Empty session returns to IDLE without done; dl_wr with dl_en low ignored.
    dl_en = 1'b1;
    tick();
    dl_en = 1'b0;
    tick();
    check("empty.done", 32'(done), 0);
    dl_wr = 1'b1; dl_addr = 25'h000001; dl_data = 8'h99;
    tick();
    dl_wr = 1'b0;
    check("noen.wr", 32'(bram_wr), 0);
    check("noen.done", 32'(done), 0);
    tick();
    check("noen.wr2", 32'(bram_wr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule
